unified_mem_arbiter: RTL and testbench

- Shares one single-port memory between the IF stage (instruction fetch) and the MEM stage (loads/stores) of riscv_pipelined_core.
- Sequences each access through a request/grant/response handshake with a variable-latency memory.
- Data accesses have priority. A starvation limit guarantees fetch progress, and a per-access timeout turns a dead memory into an error response instead of a hang.
- Sits between the pipeline stages and the memory model/bus.

---
 rtl/unified_mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 497 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, variable-latency memory between the instruction
// fetch stage (if_*) and the load/store stage (dm_*) of the pipelined core.
// Each access is a REQ/WAIT/RESP sequence. Data accesses win arbitration. A
// starvation counter forces a pending fetch through after STARVE_MAX
// consecutive data grants. A per-access timeout turns a silent memory into an
// error completion.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   if_req/if_addr         fetch request and address, held until if_ready
//   if_rdata/if_ready      fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_addr   data request, store flag, address
//   dm_wdata/dm_be         store data and byte enables
//   dm_rdata/dm_ready      load data and one-cycle completion pulse
//   bus_err                pulses with the ready of an access that timed out
//   mem_req..mem_be        registered request towards memory, held to mem_gnt
//   mem_gnt                memory accepted the request this cycle
//   mem_rvalid/mem_rdata   memory response (loads, fetches and store acks)
//   busy                   high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ready,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ready,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  state_t        state_q;
  state_t        state_d;
  logic          owner_dm_q;
  logic [SW-1:0] starve_cnt_q;
  logic [TW-1:0] tmo_cnt_q;

  logic dm_grant;
  logic if_grant;
  logic capture;
  logic abort;
  logic tmo_last;

  assign tmo_last = (tmo_cnt_q == TMO_LAST);

  // State register for the access sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. In IDLE the data port wins unless a fetch is waiting
  // and the data port has already used up its consecutive-grant allowance.
  // A same-cycle grant+response in REQ skips WAIT. Reaching the last allowed
  // cycle without a response aborts, even if the grant arrives in that cycle.
  always_comb begin
    state_d  = state_q;
    dm_grant = 1'b0;
    if_grant = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dm_req && (!if_req || (starve_cnt_q < STARVE_LIM))) begin
          dm_grant = 1'b1;
        end else if (if_req) begin
          if_grant = 1'b1;
        end
        if (dm_grant || if_grant) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt && mem_rvalid) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else if (tmo_last) begin
          abort   = 1'b1;
          state_d = S_RESP;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else if (tmo_last) begin
          abort   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. The mem_* payload is latched once at
  // grant time, so it stays stable for the whole REQ phase regardless of what
  // the requesters do. Ready/bus_err are single-cycle pulses that coincide
  // with the RESP state. The rdata registers keep their value in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_dm_q   <= 1'b0;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      if_rdata     <= '0;
      if_ready     <= 1'b0;
      dm_rdata     <= '0;
      dm_ready     <= 1'b0;
      bus_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      bus_err  <= 1'b0;
      busy     <= (state_d != S_IDLE);

      if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
        tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end

      if (dm_grant || if_grant) begin
        owner_dm_q <= dm_grant;
        tmo_cnt_q  <= '0;
        mem_req    <= 1'b1;
        mem_we     <= dm_grant & dm_we;
        mem_addr   <= dm_grant ? dm_addr : if_addr;
        mem_wdata  <= dm_grant ? dm_wdata : '0;
        mem_be     <= dm_grant ? dm_be : '1;
      end

      // Consecutive data grants only count while a fetch is actually waiting.
      if (dm_grant) begin
        if (!if_req) begin
          starve_cnt_q <= '0;
        end else if (starve_cnt_q != STARVE_LIM) begin
          starve_cnt_q <= starve_cnt_q + SW'(1);
        end
      end else if (if_grant) begin
        starve_cnt_q <= '0;
      end

      if ((state_q == S_REQ) && (state_d != S_REQ)) begin
        mem_req <= 1'b0;
      end

      // An aborted access completes with zero data and the error flag.
      if (capture || abort) begin
        bus_err <= abort;
        if (owner_dm_q) begin
          dm_ready <= 1'b1;
          dm_rdata <= capture ? mem_rdata : '0;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= capture ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Bench for unified_mem_arbiter. A memory responder with programmable grant
// and response delays stands in for the bus. A bus monitor records every
// memory request phase. The main sequence drives directed scenarios and then
// randomized traffic. Expected owner, data, latency and error status come
// from a reference memory plus the arbitration and timing rules written as
// plain arithmetic.
// ---------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [31:0]   if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic [3:0]    dm_be;
  logic [31:0]   dm_rdata;
  logic          dm_ready;
  logic          bus_err;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  int gnt_wait;
  int rv_delay;
  bit mem_dead;
  bit stray_rv;

  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cycles;
    bit          stable;
    bit          granted;
  } bus_rec_t;

  bus_rec_t bus_log [0:1023];
  int log_wr = 0;
  int log_rd = 0;

  unified_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)   return 32'h0050_0093;
    if (i == 128) return 32'h1234_5678;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    end
    return w;
  endfunction

  // Arbitration-to-ready distance: one cycle to raise mem_req, gnt_wait
  // ungranted cycles, the grant cycle, rv cycles to the response and one
  // cycle to ready; a response that would land past the last allowed cycle
  // becomes an abort at TIMEOUT+1. gap adds the IDLE cycle.
  function automatic int exp_latency(input int gw, input int rv, input int gap);
    if (gw + rv <= TIMEOUT - 1) return gw + rv + 2 + gap;
    return TIMEOUT + 1 + gap;
  endfunction

  function automatic bit exp_abort(input int gw, input int rv);
    return (gw + rv > TIMEOUT - 1);
  endfunction

  function automatic int exp_req_cycles(input int gw);
    return (gw + 1 < TIMEOUT) ? gw + 1 : TIMEOUT;
  endfunction

  // Memory responder: grants after gnt_wait ungranted cycles, answers rv_delay
  // cycles after the grant (0 = same cycle). A dead memory never grants.
  initial begin
    int          gcnt;
    bit          pend;
    int          rcnt;
    logic [31:0] rdat;
    for (int i = 0; i < 256; i++) env_mem[i] = init_word(i);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    gcnt = 0;
    pend = 1'b0;
    rcnt = 0;
    rdat = '0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (!rst_n) begin
        gcnt = 0;
      end else if (stray_rv) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end else if (pend) begin
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdat;
          pend       = 1'b0;
        end else begin
          rcnt--;
        end
      end else if (mem_req && !mem_dead) begin
        if (gcnt < gnt_wait) begin
          gcnt++;
        end else begin
          gcnt    = 0;
          mem_gnt = 1'b1;
          if (mem_we) begin
            env_mem[mem_addr[9:2]] = merge_be(env_mem[mem_addr[9:2]], mem_wdata, mem_be);
            rdat = '0;
          end else begin
            rdat = env_mem[mem_addr[9:2]];
          end
          if (rv_delay == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdat;
          end else begin
            pend = 1'b1;
            rcnt = rv_delay - 1;
          end
        end
      end else begin
        gcnt = 0;
      end
    end
  end

  // Bus monitor: one record per mem_req high phase, logged once it falls.
  initial begin
    int       cnt;
    bit       unstable;
    bit       granted;
    bus_rec_t snap;
    cnt      = 0;
    unstable = 1'b0;
    granted  = 1'b0;
    snap     = '{we: 1'b0, addr: '0, wdata: '0, be: '0, cycles: 0, stable: 1'b0, granted: 1'b0};
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        cnt      = 0;
        unstable = 1'b0;
        granted  = 1'b0;
      end else if (mem_req) begin
        if (cnt == 0) begin
          snap.we    = mem_we;
          snap.addr  = mem_addr;
          snap.wdata = mem_wdata;
          snap.be    = mem_be;
        end else if ({mem_we, mem_addr, mem_wdata, mem_be} !==
                     {snap.we, snap.addr, snap.wdata, snap.be}) begin
          unstable = 1'b1;
        end
        if (mem_gnt) granted = 1'b1;
        cnt++;
      end else if (cnt != 0) begin
        snap.cycles  = cnt;
        snap.stable  = !unstable;
        snap.granted = granted;
        bus_log[log_wr % 1024] = snap;
        log_wr++;
        cnt      = 0;
        unstable = 1'b0;
        granted  = 1'b0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input bit ireq, input logic [31:0] iaddr, input bit dreq,
                                input bit dwe, input logic [31:0] daddr,
                                input logic [31:0] dwdata, input logic [3:0] dbe);
    if_req   = ireq;
    if_addr  = iaddr;
    dm_req   = dreq;
    dm_we    = dwe;
    dm_addr  = daddr;
    dm_wdata = dwdata;
    dm_be    = dbe;
  endtask

  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_ready(input int limit, output bit got_if, output bit got_dm,
                            output bit err, output logic [31:0] ird,
                            output logic [31:0] drd, output int cycles);
    got_if = 1'b0;
    got_dm = 1'b0;
    err    = 1'b0;
    ird    = '0;
    drd    = '0;
    cycles = 0;
    while (cycles < limit) begin
      @(negedge clk);
      #2;
      cycles++;
      if (if_ready || dm_ready) begin
        got_if = if_ready;
        got_dm = dm_ready;
        err    = bus_err;
        ird    = if_rdata;
        drd    = dm_rdata;
        return;
      end
    end
    check_output("ready_within_bound", 64'(got_if | got_dm), 64'd1);
  endtask

  task automatic expect_access(input string tag, input bit exp_dm, input bit exp_err,
                               input logic [31:0] exp_rdata, input int exp_lat,
                               input logic exp_we, input logic [31:0] exp_addr,
                               input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                               input int exp_cycles);
    bit          got_if;
    bit          got_dm;
    bit          err;
    logic [31:0] ird;
    logic [31:0] drd;
    int          cyc;
    bit          have;
    bus_rec_t    r;
    wait_ready(exp_lat + 6, got_if, got_dm, err, ird, drd, cyc);
    check_output({tag, "_dm_ready"}, 64'(got_dm), 64'(exp_dm));
    check_output({tag, "_if_ready"}, 64'(got_if), 64'(!exp_dm));
    check_output({tag, "_bus_err"}, 64'(err), 64'(exp_err));
    check_output({tag, "_rdata"}, 64'(exp_dm ? drd : ird), 64'(exp_rdata));
    check_output({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    have = (log_rd < log_wr);
    check_output({tag, "_bus_seen"}, 64'(have), 64'd1);
    if (have) begin
      r = bus_log[log_rd % 1024];
      log_rd++;
      check_output({tag, "_mem_we"}, 64'(r.we), 64'(exp_we));
      check_output({tag, "_mem_addr"}, 64'(r.addr), 64'(exp_addr));
      check_output({tag, "_mem_be"}, 64'(r.be), 64'(exp_be));
      if (exp_we) check_output({tag, "_mem_wdata"}, 64'(r.wdata), 64'(exp_wdata));
      check_output({tag, "_req_cycles"}, 64'(r.cycles), 64'(exp_cycles));
      check_output({tag, "_req_stable"}, 64'(r.stable), 64'd1);
    end
  endtask

  initial begin
    bit          if_pend;
    bit          dm_pend;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dwd;
    bit          dwe_r;
    logic [3:0]  dbe_r;
    int          starve;
    int          gap;
    int          ready_seen;
    int          busy_seen;
    bit          dm_wins;
    logic [31:0] exp_d;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    gnt_wait = 0;
    rv_delay = 1;
    mem_dead = 1'b0;
    stray_rv = 1'b0;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    step_cycles(3);

    $display("[TB] reset state");
    check_output("rst_mem_req", 64'(mem_req), 64'd0);
    check_output("rst_ready", 64'({if_ready, dm_ready, bus_err}), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_mem_bus", 64'({mem_we, mem_be, mem_addr[26:0]}), 64'd0);
    check_output("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    rst_n = 1'b1;
    step_cycles(1);

    $display("[TB] single fetch");
    apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
    expect_access("fetch", 1'b0, 1'b0, 32'h0050_0093, 3, 1'b0, 32'h10, '0, 4'hF, 1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    step_cycles(1);
    check_output("fetch_ready_one_cycle", 64'(if_ready), 64'd0);
    check_output("fetch_idle_busy", 64'(busy), 64'd0);

    $display("[TB] contention");
    apply_stimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h100, 32'hCAFE_BABE, 4'h3);
    expect_access("cont_dm", 1'b1, 1'b0, 32'h0, 3, 1'b1, 32'h100, 32'hCAFE_BABE, 4'h3, 1);
    ref_mem[64] = merge_be(ref_mem[64], 32'hCAFE_BABE, 4'h3);
    apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
    expect_access("cont_if", 1'b0, 1'b0, 32'h0050_0093, 4, 1'b0, 32'h10, '0, 4'hF, 1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 4'hF);
    expect_access("cont_readback", 1'b1, 1'b0, ref_mem[64], 4, 1'b0, 32'h100, '0, 4'hF, 1);

    $display("[TB] starvation");
    apply_stimulus(1'b1, 32'h30, 1'b1, 1'b0, 32'h20, '0, 4'hF);
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) != 4)
        expect_access($sformatf("starve%0d_dm", k), 1'b1, 1'b0, ref_mem[8], 4,
                      1'b0, 32'h20, '0, 4'hF, 1);
      else
        expect_access($sformatf("starve%0d_if", k), 1'b0, 1'b0, ref_mem[12], 4,
                      1'b0, 32'h30, '0, 4'hF, 1);
    end

    $display("[TB] wait states");
    gnt_wait = 3;
    rv_delay = 5;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h200, '0, 4'hF);
    expect_access("wait_load", 1'b1, 1'b0, 32'h1234_5678, exp_latency(3, 5, 1),
                  1'b0, 32'h200, '0, 4'hF, exp_req_cycles(3));

    $display("[TB] timeout boundaries");
    gnt_wait = 13;
    rv_delay = 2;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h14, '0, 4'hF);
    expect_access("tmo_edge_ok", 1'b1, exp_abort(13, 2), ref_mem[5], exp_latency(13, 2, 1),
                  1'b0, 32'h14, '0, 4'hF, exp_req_cycles(13));
    gnt_wait = 14;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h18, '0, 4'hF);
    expect_access("tmo_edge_abort", 1'b1, exp_abort(14, 2), 32'h0, exp_latency(14, 2, 1),
                  1'b0, 32'h18, '0, 4'hF, exp_req_cycles(14));

    $display("[TB] dead memory");
    mem_dead = 1'b1;
    gnt_wait = 0;
    rv_delay = 1;
    apply_stimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
    expect_access("dead_fetch", 1'b0, 1'b1, 32'h0, TIMEOUT + 2, 1'b0, 32'h10, '0, 4'hF,
                  TIMEOUT);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    step_cycles(1);
    check_output("dead_after_idle", 64'({busy, if_ready, bus_err}), 64'd0);
    mem_dead = 1'b0;

    $display("[TB] reset during request");
    gnt_wait = 8;
    rv_delay = 0;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h40, '0, 4'hF);
    step_cycles(3);
    check_output("rst_req_pre", 64'({mem_req, busy}), 64'h3);
    rst_n = 1'b0;
    #1;
    check_output("rst_req_drop", 64'({mem_req, busy, if_ready, dm_ready}), 64'd0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    step_cycles(2);
    rst_n = 1'b1;

    $display("[TB] reset during wait");
    gnt_wait = 0;
    rv_delay = 8;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 32'h40, '0, 4'hF);
    step_cycles(3);
    check_output("rst_wait_pre", 64'({mem_req, busy}), 64'h1);
    rst_n = 1'b0;
    #1;
    check_output("rst_wait_drop", 64'({mem_req, busy, if_ready, dm_ready}), 64'd0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    step_cycles(2);
    rst_n = 1'b1;
    ready_seen = 0;
    busy_seen  = 0;
    for (int c = 0; c < 14; c++) begin
      stray_rv = (c == 2);
      step_cycles(1);
      if (if_ready || dm_ready || bus_err) ready_seen++;
      if (busy) busy_seen++;
    end
    stray_rv = 1'b0;
    check_output("stray_rvalid_ready", 64'(ready_seen), 64'd0);
    check_output("stray_rvalid_busy", 64'(busy_seen), 64'd0);
    log_rd = log_wr;

    $display("[TB] randomized traffic");
    if_pend = 1'b0;
    dm_pend = 1'b0;
    ia      = '0;
    da      = '0;
    dwd     = '0;
    dwe_r   = 1'b0;
    dbe_r   = 4'hF;
    starve  = 0;
    gap     = 0;
    for (int s = 0; s < 50; s++) begin
      if (!if_pend && ($urandom_range(0, 1) == 1)) begin
        if_pend = 1'b1;
        ia      = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!dm_pend && ($urandom_range(0, 2) != 0)) begin
        dm_pend = 1'b1;
        da      = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        dwe_r   = ($urandom_range(0, 1) == 1);
        dwd     = $urandom;
        dbe_r   = dwe_r ? 4'($urandom_range(1, 15)) : 4'hF;
      end
      if (!if_pend && !dm_pend) begin
        if_pend = 1'b1;
        ia      = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      gnt_wait = $urandom_range(0, 4);
      rv_delay = $urandom_range(0, 4);
      apply_stimulus(if_pend, ia, dm_pend, dwe_r, da, dwd, dbe_r);

      dm_wins = dm_pend && (!if_pend || (starve < STARVE_MAX));
      if (dm_wins) starve = if_pend ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
      else starve = 0;

      if (dm_wins) begin
        exp_d = dwe_r ? 32'h0 : ref_mem[da[9:2]];
        expect_access($sformatf("rnd%0d_dm", s), 1'b1, 1'b0, exp_d,
                      exp_latency(gnt_wait, rv_delay, gap), dwe_r, da, dwd, dbe_r,
                      exp_req_cycles(gnt_wait));
        if (dwe_r) ref_mem[da[9:2]] = merge_be(ref_mem[da[9:2]], dwd, dbe_r);
        dm_pend = 1'b0;
      end else begin
        expect_access($sformatf("rnd%0d_if", s), 1'b0, 1'b0, ref_mem[ia[9:2]],
                      exp_latency(gnt_wait, rv_delay, gap), 1'b0, ia, '0, 4'hF,
                      exp_req_cycles(gnt_wait));
        if_pend = 1'b0;
      end
      gap = 1;
      apply_stimulus(if_pend, ia, dm_pend, dwe_r, da, dwd, dbe_r);
    end
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    step_cycles(3);
    check_output("final_idle", 64'({busy, mem_req}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
